// File: rtl/key_poll_master_pkg.sv
// Shared keyboard definitions: poll FSM state encoding and status word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_poll_master_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } kbd_state_t;

  // Status word from the keyboard slave: [FLAG_BIT] = key pending, [VALUE_MSB:0] = key code.
  localparam int FLAG_BIT  = 4;
  localparam int VALUE_MSB = 3;

  // Written back to the slave to acknowledge (clear) the pending key.
  localparam logic [7:0] CLR_WORD = 8'h01;

endpackage

// File: rtl/key_poll_master_fifo.sv
// Key-event FIFO: small first-in first-out store for decoded key codes.
// Latency: a push is visible on pop_dat/!empty one cycle later; outputs come straight from registers.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
//   ports: clk, reset_n (async active-low), push/push_dat, pop/pop_dat, full, empty
module key_event_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/key_poll_master.sv
// Keyboard poller: periodically reads the keyboard status over Avalon-MM, acks pending keys, queues codes.
// Latency: read starts the cycle after the tick; a pending key reaches key_valid one cycle after the ack completes.
// Backpressure: bus transfers hold until avm_waitrequest=0; key_ready pops the FIFO; a push into a full FIFO sets overflow.
//   ports: clk, reset_n, enable | avm_address/read/write/writedata/readdata/waitrequest
//          | key_value/key_valid/key_ready | overflow/ovf_clr
module key_poll_master
  import key_poll_master_pkg::*;
#(
  parameter int POLL_DIV   = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic       avm_address,
  output logic       avm_read,
  output logic       avm_write,
  output logic [7:0] avm_writedata,
  input  logic [7:0] avm_readdata,
  input  logic       avm_waitrequest,
  output logic [3:0] key_value,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  kbd_state_t      state;
  kbd_state_t      state_nxt;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic            capture;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [3:0]      key_q;
  logic            unused_rdata;

  // Upper status bits carry nothing for this poller.
  assign unused_rdata = ^avm_readdata[7:FLAG_BIT+1];

  // Poll interval counter; parked at 0 whenever polling is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CW'(POLL_DIV - 1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // A tick that lands while a transfer is still running is simply skipped.
  assign tick = enable && (tick_cnt == CW'(POLL_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Bus strobes decode directly from the state register, so reset drops them asynchronously.
  always_comb begin
    state_nxt     = state;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = 8'h00;
    capture       = 1'b0;
    push          = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = READ;
        end
      end
      READ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          capture   = 1'b1;
          state_nxt = avm_readdata[FLAG_BIT] ? CLEAR : IDLE;
        end
      end
      CLEAR: begin
        avm_write     = 1'b1;
        avm_writedata = CLR_WORD;
        if (!avm_waitrequest) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign avm_address = 1'b0;

  // Key code is held from the status read until the ack completes and it is queued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q <= 4'h0;
    end else if (capture) begin
      key_q <= avm_readdata[VALUE_MSB:0];
    end
  end

  assign pop       = key_valid && key_ready;
  assign key_valid = !fifo_empty;

  key_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (4)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (key_q),
    .pop      (pop),
    .pop_dat  (key_value),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Sticky drop flag; a new drop in the same cycle beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/key_poll_master.md
KEY_POLL_MASTER -- requirements
Module: key_poll_master

Interface
REQ-001 SHALL have parameter POLL_DIV, default 50000, clk cycles between poll attempts (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, key-event FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  high = polling permitted.
REQ-006 SHALL have port avm_address  output  1  Avalon-MM master word address; always 0 when a transfer is issued.
REQ-007 SHALL have port avm_read  output  1  Avalon-MM read request.
REQ-008 SHALL have port avm_write  output  1  Avalon-MM write request.
REQ-009 SHALL have port avm_writedata  output  8  write data; 8'h01 during writes, else 8'h00.
REQ-010 SHALL have port avm_readdata  input  8  keyboard status: bit4 = flag, bits3:0 = key value; valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-011 SHALL have port avm_waitrequest  input  1  slave stall; a transfer completes only in a cycle where it is 0.
REQ-012 SHALL have port key_value  output  4  head-of-FIFO key code.
REQ-013 SHALL have port key_valid  output  1  FIFO non-empty.
REQ-014 SHALL have port key_ready  input  1  consumer accept; pop when key_valid and key_ready are both 1.
REQ-015 SHALL have port overflow  output  1  sticky: a key event was dropped.
REQ-016 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-017 SHALL implement FSM states IDLE, READ and CLEAR.
REQ-018 SHALL run a tick counter 0..POLL_DIV-1 while enable=1, wrapping to 0; held at 0 while enable=0.
REQ-019 SHALL go IDLE->READ in the cycle after the counter reaches POLL_DIV-1 with enable=1.
REQ-020 SHALL assert avm_read=1 and avm_address=0 throughout READ, holding them stable until avm_waitrequest=0.
REQ-021 SHALL, on READ completion, capture avm_readdata[3:0]; go READ->CLEAR if avm_readdata[4]=1, else READ->IDLE.
REQ-022 SHALL assert avm_write=1, avm_address=0 and avm_writedata=8'h01 throughout CLEAR, holding them stable until avm_waitrequest=0.
REQ-023 SHALL push the captured value into the FIFO in the CLEAR completion cycle, then go CLEAR->IDLE.
REQ-024 SHALL never assert avm_read and avm_write together; both outputs are 0 in IDLE.
REQ-025 SHALL let a transfer already in progress complete when enable falls mid-transfer; no new poll starts.
REQ-026 SHALL keep FIFO order first-in first-out; key_value and key_valid are registered, with 1-cycle push-to-visible latency.
REQ-027 SHALL, on push while full with no pop, drop the new value, keep the FIFO contents unchanged, and set overflow=1.
REQ-028 SHALL accept a push while full if a pop occurs in the same cycle; count unchanged, no overflow.
REQ-029 SHALL treat push and pop in the same cycle on an empty FIFO as push only (key_valid is 0, so no pop occurs).
REQ-030 SHALL make a set of overflow win over ovf_clr in the same cycle.
REQ-031 SHALL accept, as a documented limit, that a key latched by the slave between READ and CLEAR may be lost.

Reset
REQ-032 SHALL, with reset_n=0, immediately drive: state IDLE, counter 0, avm_read/avm_write 0, avm_address 0, avm_writedata 8'h00, FIFO empty, key_valid 0, key_value 4'h0, overflow 0.
REQ-033 SHALL abandon any in-flight transfer on reset; bus outputs deassert asynchronously.

Structure
REQ-034 SHALL place the state encoding, the status bit positions (FLAG_BIT=4, VALUE_MSB=3) and CLR_WORD=8'h01 in a shared keyboard package.
REQ-035 SHALL implement the FIFO as sub-module key_event_fifo (parameter FIFO_DEPTH, width 4, push/pop/full/empty).

Verification
REQ-036 SHALL show, with POLL_DIV=4, enable=1, waitrequest=0 and readdata=8'h00, a read every 4 cycles and no writes.
REQ-037 SHALL show, for readdata=8'h17, one read, then one write of 8'h01, then key_valid=1 with key_value=4'h7.
REQ-038 SHALL show, with waitrequest held 3 cycles during READ then CLEAR, address/read/write stable; exactly one read and one write complete.
REQ-039 SHALL show, for 5 events 1..5 with key_ready=0 and FIFO_DEPTH=4, FIFO holding 1..4, overflow=1; after ovf_clr, overflow=0.
REQ-040 SHALL show a full FIFO with push and pop in the same cycle: no overflow, order preserved.
REQ-041 SHALL show reset_n=0 asserted during CLEAR with waitrequest=1: avm_write=0 immediately, FIFO empty, restart in IDLE.
